// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_n block.
//   MODE_DIRECT / MODE_RR : encodings of the mode input
//   clog2()               : index width for a channel count
package stream_mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Smallest r with 2**r >= v, and at least 1 so a 1-bit index always exists.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational wrap-around priority search.
//   req     : per-channel request
//   ptr     : last granted index; the search starts at ptr+1
//   gnt_oh  : one-hot grant
//   gnt_idx : granted index
//   gnt_vld : some request was found
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  // k = 1 is tried first, so the channel right after ptr has top priority
  // and ptr itself has the lowest.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (int'(ptr) + k) % NUM_CH;
      if (!gnt_vld && req[c]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = SEL_W'(c);
        gnt_oh[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream selector with a registered output stage.
//   clk, rst_n   : clock, synchronous active-low reset
//   mode, sel    : 0 = direct select by sel, 1 = round-robin
//   in_data      : packed channel words, channel i at [i*DATA_W +: DATA_W]
//   in_valid     : per-channel valid
//   in_ready     : per-channel ready (combinational, at most one set)
//   out_data/ch  : registered word and the channel it came from
//   out_valid    : registered valid
//   out_ready    : consumer ready
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [NUM_CH-1:0] rr_oh, dir_oh, grant_oh;
  logic [SEL_W-1:0]  rr_idx, grant_idx;
  logic              rr_vld, dir_vld, grant_vld;
  logic              load_en, xfer;
  logic [DATA_W-1:0] grant_data;

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_oh  (rr_oh),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Direct grant by comparison against every legal index, so an
  // out-of-range sel simply matches nothing.
  always_comb begin
    dir_oh  = '0;
    dir_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel == SEL_W'(i) && in_valid[i]) begin
        dir_oh[i] = 1'b1;
        dir_vld   = 1'b1;
      end
  end

  assign grant_oh  = (mode == MODE_RR) ? rr_oh  : dir_oh;
  assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign grant_vld = (mode == MODE_RR) ? rr_vld : dir_vld;

  assign load_en = !out_valid_q || out_ready;
  // Gated by rst_n so nothing handshakes in a reset cycle.
  assign xfer    = rst_n && load_en && grant_vld;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant_oh[i]) grant_data = in_data[i*DATA_W +: DATA_W];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rdy
    assign in_ready[i] = xfer && grant_oh[i];
  end

  // out_data/out_ch keep their last values when the word drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
        if (mode == MODE_RR) rr_ptr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Drives a 4-channel and a 3-channel instance from one stimulus stream
// (the 3-channel one sees channels 0..2, so sel=3 is out of range for it)
// and compares both against a cycle-level behavioural model.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] din;
  logic [3:0]  vld;
  logic        out_ready;

  logic [3:0] rdy4, od4;
  logic [1:0] och4;
  logic       ov4;
  logic [2:0] rdy3;
  logic [3:0] od3;
  logic [1:0] och3;
  logic       ov3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_mux_n #(.NUM_CH(4), .DATA_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(din), .in_valid(vld), .in_ready(rdy4),
    .out_data(od4), .out_valid(ov4), .out_ch(och4), .out_ready(out_ready)
  );

  stream_mux_n #(.NUM_CH(3), .DATA_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(din[11:0]), .in_valid(vld[2:0]), .in_ready(rdy3),
    .out_data(od3), .out_valid(ov3), .out_ch(och3), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Model state: what the consumer sees plus the last round-robin winner.
  typedef struct {
    bit       ov;
    bit [3:0] od;
    int       och;
    int       ptr;
  } mst_t;

  mst_t s4 = '{0, 4'h0, 0, 3};
  mst_t s3 = '{0, 4'h0, 0, 2};

  // Channel the current inputs would be granted, or -1.
  function automatic int mgrant(mst_t s, int n);
    if (mode) begin
      for (int k = 1; k <= n; k++)
        if (vld[(s.ptr + k) % n]) return (s.ptr + k) % n;
      return -1;
    end
    if (int'(sel) < n && vld[sel]) return int'(sel);
    return -1;
  endfunction

  function automatic int mready(mst_t s, int n);
    int g;
    g = mgrant(s, n);
    if (rst_n && (!s.ov || out_ready) && g >= 0) return 1 << g;
    return 0;
  endfunction

  function automatic mst_t mnext(mst_t s, int n);
    mst_t r;
    int   g;
    r = s;
    g = mgrant(s, n);
    if (!rst_n) begin
      r = '{0, 4'h0, 0, n - 1};
    end else if (!s.ov || out_ready) begin
      if (g >= 0) begin
        r.ov  = 1;
        r.od  = din[g*4 +: 4];
        r.och = g;
        if (mode) r.ptr = g;
      end else begin
        r.ov = 0;
      end
    end
    return r;
  endfunction

  // One clock: compare both instances at the falling edge, advance the
  // model, and return 1 time unit after the rising edge.
  task automatic cyc();
    mst_t n4, n3;
    @(negedge clk);
    chk("ov4",  int'(ov4),  int'(s4.ov));
    chk("od4",  int'(od4),  int'(s4.od));
    chk("och4", int'(och4), s4.och);
    chk("rdy4", int'(rdy4), mready(s4, 4));
    chk("ov3",  int'(ov3),  int'(s3.ov));
    chk("od3",  int'(od3),  int'(s3.od));
    chk("och3", int'(och3), s3.och);
    chk("rdy3", int'(rdy3), mready(s3, 3));
    n4 = mnext(s4, 4);
    n3 = mnext(s3, 3);
    @(posedge clk);
    #1;
    s4 = n4;
    s3 = n3;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0;
    din = 16'hDCBA; vld = 4'hF; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with every channel valid.
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_ov", int'(ov4), 0);
      chk("rst_rdy", int'(rdy4), 0);
    end
    rst_n = 1'b1;

    // Round-robin from reset: 0,1,2,3,0,1 back to back.
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rr_seq", int'(och4), k % 4);
      chk("rr_ov", int'(ov4), 1);
    end

    // Direct select stepping through channels.
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      cyc();
      chk("dir_ch", int'(och4), k);
      chk("dir_data", int'(od4), 10 + k);
    end

    // Back-pressure holds word D.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_data", int'(od4), 13);
      chk("bp_ch", int'(och4), 3);
      chk("bp_rdy", int'(rdy4), 0);
    end
    out_ready = 1'b1;
    sel = 2'd0;
    cyc();
    chk("bp_rel_ov", int'(ov4), 1);
    chk("bp_rel_data", int'(od4), 10);

    // Sparse round-robin: park the pointer on 1, then ch1+ch3 valid.
    mode = 1'b1;
    vld = 4'b0010;
    cyc();
    chk("sp_park", int'(och4), 1);
    vld = 4'b1010;
    cyc();
    chk("sp_first", int'(och4), 3);
    cyc();
    chk("sp_second", int'(och4), 1);

    // Out-of-range sel on the 3-channel instance drains it.
    mode = 1'b0; sel = 2'd3; vld = 4'hF;
    cyc();
    cyc();
    chk("bad_sel_ov", int'(ov3), 0);
    chk("bad_sel_rdy", int'(rdy3), 0);

    // Reset while a word is held under back-pressure.
    sel = 2'd2;
    cyc();
    out_ready = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_ov", int'(ov4), 0);
    rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1;
    cyc();
    chk("post_rst_ch", int'(och4), 0);
    chk("post_rst_data", int'(od4), 10);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom);
      vld       = 4'($urandom);
      din       = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
